rom_bus_arbiter: RTL and testbench

- Two-requester arbiter for the ROM's TileLink-UL port.
- Multiplexes A-channel requests from master 0 (instruction fetch) and master 1 (data/debug loader) onto the single ROM slave port.
- Routes each D-channel response back to the master that issued the request.
- One transaction outstanding at a time; round-robin fairness; sits between the masters and the rom instance.

---
 rtl/rom_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
// Two-master round-robin arbiter in front of the ROM TileLink-UL port.
// Latency: A handshake -> s_a_valid 1 cycle; D path is a combinational pass-through.
// Backpressure: one transaction outstanding; m*_a_ready low in REQ/RESP, s_d_ready follows granted d_ready.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   m0_a_* / m0_d_*             master 0 (instruction fetch) A request / D response
//   m1_a_* / m1_d_*             master 1 (data/debug loader) A request / D response
//   s_a_* / s_d_*               ROM slave A request (registered) / D response
//   err_stray_d                 sticky flag: ROM response seen outside RESP
module rom_bus_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int ABW = AW + 6,
  parameter int DBW = DW + 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m0_a_valid,
  output logic           m0_a_ready,
  input  logic [ABW-1:0] m0_a_bits,
  output logic           m0_d_valid,
  input  logic           m0_d_ready,
  output logic [DBW-1:0] m0_d_bits,
  input  logic           m1_a_valid,
  output logic           m1_a_ready,
  input  logic [ABW-1:0] m1_a_bits,
  output logic           m1_d_valid,
  input  logic           m1_d_ready,
  output logic [DBW-1:0] m1_d_bits,
  output logic           s_a_valid,
  input  logic           s_a_ready,
  output logic [ABW-1:0] s_a_bits,
  input  logic           s_d_valid,
  output logic           s_d_ready,
  input  logic [DBW-1:0] s_d_bits,
  output logic           err_stray_d
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_grant;
  logic           r_last_grant;
  logic [ABW-1:0] r_a_bits;
  logic           r_err;

  logic           w_sel;
  logic           w_a_fire;

  // Round-robin: on a tie the master that did not win last time goes next.
  always_comb begin
    if (m0_a_valid && m1_a_valid) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = m1_a_valid;
    end
  end

  assign w_a_fire = (r_state == S_IDLE) && (m0_a_valid || m1_a_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a_bits     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_a_fire) begin
        r_a_bits     <= w_sel ? m1_a_bits : m0_a_bits;
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
      end
      if (s_d_valid && (r_state != S_RESP)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m0_a_ready  = 1'b0;
    m1_a_ready  = 1'b0;
    m0_d_valid  = 1'b0;
    m1_d_valid  = 1'b0;
    m0_d_bits   = '0;
    m1_d_bits   = '0;
    s_a_valid   = 1'b0;
    s_d_ready   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Ready is held off during reset: a handshake then would be lost
        // because the payload register cannot capture it.
        if (w_a_fire && rst_n) begin
          m0_a_ready  = ~w_sel;
          m1_a_ready  = w_sel;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        s_a_valid = 1'b1;
        if (s_a_ready) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_grant) begin
          m1_d_valid = s_d_valid;
          m1_d_bits  = s_d_bits;
          s_d_ready  = m1_d_ready;
        end else begin
          m0_d_valid = s_d_valid;
          m0_d_bits  = s_d_bits;
          s_d_ready  = m0_d_ready;
        end
        if (s_d_valid && s_d_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign s_a_bits    = r_a_bits;
  assign err_stray_d = r_err;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed self-checking bench for rom_bus_arbiter.
// Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
// Expected values are hand-derived constants.
module tb_rom_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int ABW = AW + 6;
  localparam int DBW = DW + 3;

  logic           clk;
  logic           rst_n;
  logic           m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready;
  logic [ABW-1:0] m0_a_bits;
  logic [DBW-1:0] m0_d_bits;
  logic           m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready;
  logic [ABW-1:0] m1_a_bits;
  logic [DBW-1:0] m1_d_bits;
  logic           s_a_valid, s_a_ready, s_d_valid, s_d_ready;
  logic [ABW-1:0] s_a_bits;
  logic [DBW-1:0] s_d_bits;
  logic           err_stray_d;

  int checks = 0;
  int errors = 0;

  rom_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_bits(m0_a_bits),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_bits(m0_d_bits),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_bits(m1_a_bits),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_bits(m1_d_bits),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits(s_a_bits),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits(s_d_bits),
    .err_stray_d(err_stray_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven, outputs checked after #1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [ABW-1:0] a0, a1, a_exp;
  logic [DBW-1:0] d_exp;

  initial begin
    rst_n = 1'b0;
    m0_a_valid = 0; m0_a_bits = '0; m0_d_ready = 0;
    m1_a_valid = 0; m1_a_bits = '0; m1_d_ready = 0;
    s_a_ready = 0; s_d_valid = 0; s_d_bits = '0;
    #1;
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_s_a_bits", s_a_bits, 0);
    chk("rst_err", err_stray_d, 0);
    chk("rst_a_ready", {m0_a_ready, m1_a_ready}, 0);
    chk("rst_d_valid", {m0_d_valid, m1_d_valid, s_d_ready}, 0);
    step();
    step();
    rst_n = 1'b1;

    // ---- single m0 read ----
    step();
    a_exp = {3'd4, 3'd3, 32'h0000_0100};
    m0_a_valid = 1; m0_a_bits = a_exp;
    #1;
    chk("t1_m0_a_ready", m0_a_ready, 1);
    chk("t1_m1_a_ready", m1_a_ready, 0);
    chk("t1_s_a_valid_idle", s_a_valid, 0);
    step();
    m0_a_valid = 0; m0_a_bits = '0; s_a_ready = 1;
    #1;
    chk("t1_s_a_valid", s_a_valid, 1);
    chk("t1_s_a_bits", s_a_bits, a_exp);
    chk("t1_m0_a_ready_req", m0_a_ready, 0);
    step();
    s_a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_m0_d_valid_wait", m0_d_valid, 0);
      step();
    end
    d_exp = {3'd1, 64'h1122_3344_5566_7788};
    s_d_valid = 1; s_d_bits = d_exp; m0_d_ready = 1;
    #1;
    chk("t1_m0_d_valid", m0_d_valid, 1);
    chk("t1_m0_d_bits", m0_d_bits, d_exp);
    chk("t1_m1_d_valid", m1_d_valid, 0);
    chk("t1_m1_d_bits", m1_d_bits, 0);
    chk("t1_s_d_ready", s_d_ready, 1);
    step();
    s_d_valid = 0; s_d_bits = '0; m0_d_ready = 0;
    #1;
    chk("t1_idle_s_a_valid", s_a_valid, 0);
    chk("t1_idle_s_d_ready", s_d_ready, 0);
    chk("t1_idle_m0_d_valid", m0_d_valid, 0);

    // ---- round robin, both valid from reset ----
    rst_n = 0;
    step();
    rst_n = 1;
    a0 = {3'd4, 3'd0, 32'h0000_0010};
    a1 = {3'd1, 3'd2, 32'h0000_0020};
    m0_a_valid = 1; m0_a_bits = a0;
    m1_a_valid = 1; m1_a_bits = a1;
    m0_d_ready = 1; m1_d_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_m0_a_ready", m0_a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_m1_a_ready", m1_a_ready, (i % 2 == 1) ? 1 : 0);
      step();
      s_a_ready = 1;
      #1;
      chk("rr_s_a_bits", s_a_bits, (i % 2 == 0) ? a0 : a1);
      chk("rr_a_ready_req", {m0_a_ready, m1_a_ready}, 0);
      step();
      s_a_ready = 0;
      d_exp = {3'd1, 64'h0};
      d_exp[7:0] = 8'hD0 + 8'(i);
      s_d_valid = 1; s_d_bits = d_exp;
      #1;
      if (i % 2 == 0) begin
        chk("rr_m0_d_valid", m0_d_valid, 1);
        chk("rr_m0_d_bits", m0_d_bits, d_exp);
        chk("rr_m1_d_valid", m1_d_valid, 0);
      end else begin
        chk("rr_m1_d_valid", m1_d_valid, 1);
        chk("rr_m1_d_bits", m1_d_bits, d_exp);
        chk("rr_m0_d_valid", m0_d_valid, 0);
      end
      step();
      s_d_valid = 0; s_d_bits = '0;
    end
    m0_a_valid = 0; m1_a_valid = 0;
    m0_d_ready = 0; m1_d_ready = 0;
    step();

    // ---- ROM stalls A channel for 5 cycles ----
    a_exp = {3'd4, 3'd1, 32'h0000_0A40};
    m0_a_valid = 1; m0_a_bits = a_exp;
    #1;
    chk("st_m0_a_ready", m0_a_ready, 1);
    step();
    m0_a_valid = 0; m0_a_bits = '0; m1_a_valid = 1; m1_a_bits = a1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_s_a_valid", s_a_valid, 1);
      chk("st_s_a_bits", s_a_bits, a_exp);
      chk("st_a_ready", {m0_a_ready, m1_a_ready}, 0);
      step();
    end
    s_a_ready = 1;
    step();
    s_a_ready = 0;
    s_d_valid = 1; s_d_bits = {3'd1, 64'h55}; m0_d_ready = 1;
    #1;
    chk("st_m1_a_ready_resp", m1_a_ready, 0);
    chk("st_m0_d_valid", m0_d_valid, 1);
    step();
    s_d_valid = 0; m0_d_ready = 0;

    // ---- granted m1 holds d_ready low for 3 cycles ----
    #1;
    chk("bp_m1_a_ready", m1_a_ready, 1);
    step();
    m1_a_valid = 0; s_a_ready = 1;
    step();
    s_a_ready = 0;
    d_exp = {3'd1, 64'hCAFE_F00D_0000_0001};
    s_d_valid = 1; s_d_bits = d_exp;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_d_ready_low", s_d_ready, 0);
      chk("bp_m1_d_valid", m1_d_valid, 1);
      chk("bp_m0_d_valid", m0_d_valid, 0);
      step();
    end
    m1_d_ready = 1;
    #1;
    chk("bp_s_d_ready_high", s_d_ready, 1);
    chk("bp_m1_d_bits", m1_d_bits, d_exp);
    step();
    s_d_valid = 0; s_d_bits = '0; m1_d_ready = 0;
    #1;
    chk("bp_done_d_valid", m1_d_valid, 0);
    chk("bp_no_err", err_stray_d, 0);

    // ---- stray response in IDLE ----
    step();
    s_d_valid = 1; s_d_bits = {3'd1, 64'h99};
    m0_d_ready = 1; m1_d_ready = 1;
    #1;
    chk("sd_d_valid", {m0_d_valid, m1_d_valid}, 0);
    chk("sd_s_d_ready", s_d_ready, 0);
    chk("sd_err_same", err_stray_d, 0);
    step();
    s_d_valid = 0; s_d_bits = '0; m0_d_ready = 0; m1_d_ready = 0;
    #1;
    chk("sd_err_next", err_stray_d, 1);
    step();
    #1;
    chk("sd_err_sticky", err_stray_d, 1);

    // ---- reset during RESP ----
    a_exp = {3'd4, 3'd3, 32'h0000_0200};
    m0_a_valid = 1; m0_a_bits = a_exp;
    step();
    m0_a_valid = 0; s_a_ready = 1;
    step();
    s_a_ready = 0;
    s_d_valid = 1; s_d_bits = {3'd1, 64'h77};
    #1;
    chk("rr_pre_m0_d_valid", m0_d_valid, 1);
    rst_n = 0;
    #1;
    chk("rs_s_a_valid", s_a_valid, 0);
    chk("rs_s_a_bits", s_a_bits, 0);
    chk("rs_err", err_stray_d, 0);
    chk("rs_outs", {m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready}, 0);
    s_d_valid = 0; s_d_bits = '0;
    step();
    rst_n = 1;
    m1_a_valid = 1; m1_a_bits = a1;
    #1;
    chk("rs_m1_a_ready", m1_a_ready, 1);
    step();
    m1_a_valid = 0; s_a_ready = 1;
    #1;
    chk("rs_s_a_bits_m1", s_a_bits, a1);
    step();
    s_a_ready = 0;
    s_d_valid = 1; s_d_bits = {3'd1, 64'h42}; m1_d_ready = 1;
    #1;
    chk("rs_m1_d_valid", m1_d_valid, 1);
    step();
    s_d_valid = 0; m1_d_ready = 0;
    #1;
    chk("rs_idle", {s_a_valid, s_d_ready, m1_d_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
